// File: rtl/mux_round_robin_arbiter_if.sv
// rtl/mux_round_robin_arbiter_if.sv - requester-side and consumer-side signals of the shared mux
interface mux_round_robin_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            Request_In;
  logic [NUM_REQ-1:0]            Last_In;
  logic [NUM_REQ*DATA_WIDTH-1:0] Data_In;
  logic [NUM_REQ-1:0]            Grant_Out;
  logic [SEL_W-1:0]              Select_Out;
  logic [DATA_WIDTH-1:0]         MUX_Data_Out;
  logic                          Valid_Out;

  modport slave (
    input  Request_In, Last_In, Data_In,
    output Grant_Out, Select_Out, MUX_Data_Out, Valid_Out
  );

  modport master (
    output Request_In, Last_In, Data_In,
    input  Grant_Out, Select_Out, MUX_Data_Out, Valid_Out
  );
endinterface

// File: rtl/mux_round_robin_arbiter.sv
// rtl/mux_round_robin_arbiter.sv - round-robin burst arbiter steering a registered NUM_REQ:1 mux
module mux_round_robin_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 8
) (
  input  logic Clock_In,
  input  logic Reset_N_In,
  input  logic Enable_In,
  mux_round_robin_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]      select_q, select_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  win_found;
  logic [SEL_W-1:0]      win_idx;
  logic                  owner_req;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;

  // Scan starts just past the previous owner so it becomes lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && bus.Request_In[(int'(ptr_q) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign owner_req  = bus.Request_In[select_q];
  assign owner_last = bus.Last_In[select_q];
  assign owner_data = bus.Data_In[int'(select_q)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= '0;
      ptr_q    <= SEL_W'(NUM_REQ - 1);
      data_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (Enable_In && win_found) begin
          grant_d  = NUM_REQ'(1) << win_idx;
          select_d = win_idx;
          ptr_d    = win_idx;
          cnt_d    = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (Enable_In && owner_req) begin
          data_d  = owner_data;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          // Final beat is still delivered on the releasing edge.
          if (owner_last || cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Grant_Out    = grant_q;
  assign bus.Select_Out   = select_q;
  assign bus.MUX_Data_Out = data_q;
  assign bus.Valid_Out    = valid_q;
endmodule
